// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, last-winner tag and grant codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } state_t;

  typedef enum logic {
    WIN_I = 1'b0,
    WIN_D = 1'b1
  } winner_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  function automatic logic [1:0] gnt_of(state_t s);
    case (s)
      INSTR:   gnt_of = GNT_I;
      DATA:    gnt_of = GNT_D;
      default: gnt_of = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Ack timeout counter for the memory port; exists only when
// MEM_PORT_ARB_TIMEOUT_EN is defined.
`ifdef MEM_PORT_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic a_clk,
  input  logic a_rst,
  input  logic m_syn,
  input  logic m_ack,
  output logic tout,
  output logic err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  // Fires in the TIMEOUT-th waiting cycle so the port drops on that edge.
  assign tout = m_syn & ~m_ack & (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge a_clk or posedge a_rst)
    if (a_rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= tout;
      if (!m_syn || m_ack || tout) cnt <= '0;
      else                         cnt <= cnt + TW'(1);
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (bursts) and load/store (single beat).
// Optional ack watchdog enabled by MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic              a_i_flush,
  input  logic              a_i_syn,
  input  logic [AWIDTH-1:0] a_i_addr,
  output logic              a_o_i_ack,
  output logic              a_o_i_last,
  output logic [DWIDTH-1:0] a_o_i_instr,
  input  logic              a_d_syn,
  input  logic              a_d_we,
  input  logic [AWIDTH-1:0] a_d_addr,
  input  logic [DWIDTH-1:0] a_d_wdata,
  output logic              a_o_d_ack,
  output logic [DWIDTH-1:0] a_o_d_rdata,
  output logic              a_o_m_syn,
  output logic              a_o_m_we,
  output logic [AWIDTH-1:0] a_o_m_addr,
  output logic [DWIDTH-1:0] a_o_m_wdata,
  input  logic              a_i_m_ack,
  input  logic [DWIDTH-1:0] a_i_m_rdata,
  input  logic              a_i_m_last,
  output logic [1:0]        a_o_grant,
  output logic              a_o_err
);
  localparam int CW = $clog2(MAX_BURST + 1);

  if (MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_port_arbiter: MAX_BURST and TIMEOUT must be >= 1");
  end

  state_t        state, state_n;
  winner_t       last_win;
  logic [CW-1:0] beat_cnt;
  logic          in_i, in_d, tout;

  assign in_i = (state == INSTR);
  assign in_d = (state == DATA);

  assign a_o_i_ack   = in_i & a_i_m_ack & ~a_i_flush;
  assign a_o_i_last  = a_o_i_ack & (a_i_m_last | (beat_cnt == CW'(MAX_BURST - 1)) |
                                    a_d_syn | ~a_i_syn);
  assign a_o_i_instr = in_i ? a_i_m_rdata : '0;
  assign a_o_d_ack   = in_d & a_i_m_ack;
  assign a_o_d_rdata = in_d ? a_i_m_rdata : '0;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .a_clk (a_clk),
    .a_rst (a_rst),
    .m_syn (a_o_m_syn),
    .m_ack (a_i_m_ack),
    .tout  (tout),
    .err   (a_o_err)
  );
`else
  assign tout    = 1'b0;
  assign a_o_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      // Contention goes to whoever did not win last time.
      IDLE:    if (a_i_syn && (!a_d_syn || last_win == WIN_D)) state_n = INSTR;
               else if (a_d_syn)                               state_n = DATA;
      INSTR:   if (a_i_flush || a_o_i_last || tout)            state_n = IDLE;
      DATA:    if (a_o_d_ack || tout)                          state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge a_clk or posedge a_rst)
    if (a_rst) begin
      state       <= IDLE;
      last_win    <= WIN_D;
      beat_cnt    <= '0;
      a_o_m_syn   <= 1'b0;
      a_o_m_we    <= 1'b0;
      a_o_m_addr  <= '0;
      a_o_m_wdata <= '0;
      a_o_grant   <= GNT_NONE;
    end else begin
      state     <= state_n;
      a_o_m_syn <= (state_n != IDLE);
      a_o_grant <= gnt_of(state_n);
      if (state == IDLE && state_n == INSTR) begin
        a_o_m_addr <= a_i_addr;
        a_o_m_we   <= 1'b0;
      end else if (state == IDLE && state_n == DATA) begin
        a_o_m_addr  <= a_d_addr;
        a_o_m_we    <= a_d_we;
        a_o_m_wdata <= a_d_wdata;
      end else if (in_i && state_n == INSTR && a_o_i_ack) begin
        a_o_m_addr <= a_i_addr;
      end else if (state_n == IDLE) begin
        a_o_m_we <= 1'b0;
      end
      if (state_n == IDLE)  beat_cnt <= '0;
      else if (a_o_i_ack)   beat_cnt <= beat_cnt + CW'(1);
      if (state != IDLE && state_n == IDLE)
        last_win <= in_i ? WIN_I : WIN_D;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a port-ownership model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MB = 4, TO = 8;

  logic          a_clk = 1'b0, a_rst = 1'b1;
  logic          a_i_flush = 0, a_i_syn = 0, a_d_syn = 0, a_d_we = 0;
  logic [AW-1:0] a_i_addr = '0, a_d_addr = '0;
  logic [DW-1:0] a_d_wdata = '0, a_i_m_rdata = '0;
  logic          a_i_m_ack = 0, a_i_m_last = 0;
  logic          a_o_i_ack, a_o_i_last, a_o_d_ack, a_o_m_syn, a_o_m_we, a_o_err;
  logic [DW-1:0] a_o_i_instr, a_o_d_rdata, a_o_m_wdata;
  logic [AW-1:0] a_o_m_addr;
  logic [1:0]    a_o_grant;

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .a_clk(a_clk), .a_rst(a_rst), .a_i_flush(a_i_flush), .a_i_syn(a_i_syn),
    .a_i_addr(a_i_addr), .a_o_i_ack(a_o_i_ack), .a_o_i_last(a_o_i_last),
    .a_o_i_instr(a_o_i_instr), .a_d_syn(a_d_syn), .a_d_we(a_d_we), .a_d_addr(a_d_addr),
    .a_d_wdata(a_d_wdata), .a_o_d_ack(a_o_d_ack), .a_o_d_rdata(a_o_d_rdata),
    .a_o_m_syn(a_o_m_syn), .a_o_m_we(a_o_m_we), .a_o_m_addr(a_o_m_addr),
    .a_o_m_wdata(a_o_m_wdata), .a_i_m_ack(a_i_m_ack), .a_i_m_rdata(a_i_m_rdata),
    .a_i_m_last(a_i_m_last), .a_o_grant(a_o_grant), .a_o_err(a_o_err)
  );

  always #5 a_clk = ~a_clk;

  int checks = 0, errors = 0;

  // Reference: who owns the port, what was latched for it, beats delivered so far.
  int            owner;        // 0 none, 1 fetch, 2 data
  bit            last_was_i;
  int            beats;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;

  logic          s_i_ack, s_i_last, s_d_ack;
  logic [1:0]    s_grant;
  logic [DW-1:0] s_d_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; last_was_i = 0; beats = 0;
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    {a_i_flush, a_i_syn, a_d_syn, a_d_we, a_i_m_ack, a_i_m_last} = '0;
    @(posedge a_clk); #1;
    chk("rst_grant", a_o_grant, 0);
    chk("rst_m_syn", a_o_m_syn, 0);
    chk("rst_m_we", a_o_m_we, 0);
    chk("rst_m_addr", a_o_m_addr, 0);
    chk("rst_i_ack", a_o_i_ack, 0);
    chk("rst_d_ack", a_o_d_ack, 0);
    chk("rst_err", a_o_err, 0);
    a_rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit isyn, input bit dsyn, input bit dwe, input bit flush,
                      input bit mack, input bit mlast, input logic [AW-1:0] iaddr,
                      input logic [AW-1:0] daddr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] rdata);
    bit e_iack, e_ilast, e_dack;
    a_i_syn = isyn; a_d_syn = dsyn; a_d_we = dwe; a_i_flush = flush;
    a_i_m_ack = mack; a_i_m_last = mlast; a_i_addr = iaddr; a_d_addr = daddr;
    a_d_wdata = wdata; a_i_m_rdata = rdata;
    #2;
    e_iack  = (owner == 1) && mack && !flush;
    e_ilast = e_iack && (mlast || beats == MB - 1 || dsyn || !isyn);
    e_dack  = (owner == 2) && mack;
    chk("grant", a_o_grant, (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00);
    chk("m_syn", a_o_m_syn, owner != 0);
    chk("i_ack", a_o_i_ack, e_iack);
    chk("i_last", a_o_i_last, e_ilast);
    chk("d_ack", a_o_d_ack, e_dack);
    chk("err", a_o_err, 0);
    if (owner != 0) begin
      chk("m_addr", a_o_m_addr, r_addr);
      chk("m_we", a_o_m_we, (owner == 2) ? r_we : 1'b0);
    end
    if (owner == 2) chk("m_wdata", a_o_m_wdata, r_wdata);
    if (e_iack) chk("i_instr", a_o_i_instr, rdata);
    if (e_dack) chk("d_rdata", a_o_d_rdata, rdata);
    s_i_ack = a_o_i_ack; s_i_last = a_o_i_last; s_d_ack = a_o_d_ack;
    s_grant = a_o_grant; s_d_rdata = a_o_d_rdata;
    case (owner)
      0: if (isyn && (!dsyn || !last_was_i)) begin
           owner = 1; r_addr = iaddr; r_we = 1'b0;
         end else if (dsyn) begin
           owner = 2; r_addr = daddr; r_we = dwe; r_wdata = wdata;
         end
      1: if (flush || e_ilast) begin
           owner = 0; last_was_i = 1; beats = 0;
         end else if (e_iack) begin
           beats++; r_addr = iaddr;
         end
      default: if (e_dack) begin owner = 0; last_was_i = 0; end
    endcase
    @(posedge a_clk); #1;
  endtask

  task automatic simple(input bit isyn, input bit dsyn, input bit flush, input bit mack);
    step(isyn, dsyn, 1'b0, flush, mack, 1'b0, 32'h100 + $urandom_range(0, 255),
         32'h40, $urandom, $urandom);
  endtask

  initial begin
    int n_iack;
    bit ri, rd;
    model_reset();
    do_reset();

    // Data-only load, memory acks two cycles after the request.
    step(0, 1, 0, 0, 0, 0, '0, 32'h40, '0, '0);
    step(0, 1, 0, 0, 0, 0, '0, 32'h40, '0, '0);
    chk("dir_d_grant", s_grant, 2'b10);
    step(0, 1, 0, 0, 1, 0, '0, 32'h40, '0, 32'hDEADBEEF);
    chk("dir_d_ack", s_d_ack, 1);
    chk("dir_d_rdata", s_d_rdata, 32'hDEADBEEF);
    simple(0, 0, 0, 0);
    chk("dir_d_idle", s_grant, 2'b00);

    // Fetch burst capped at MAX_BURST beats.
    simple(1, 0, 0, 0);
    n_iack = 0;
    for (int k = 0; k < MB; k++) begin
      simple(1, 0, 0, 1);
      n_iack += int'(s_i_ack);
      if (k == MB - 1) chk("dir_burst_last", s_i_last, 1);
    end
    chk("dir_burst_beats", n_iack, MB);
    simple(1, 0, 0, 0);
    chk("dir_burst_gap", s_grant, 2'b00);

    // Data request preempts beat 2, then alternation returns to fetch.
    simple(1, 0, 0, 1);
    simple(1, 1, 0, 1);
    chk("dir_pre_last", s_i_last, 1);
    simple(1, 1, 0, 0);
    simple(1, 1, 0, 1);
    chk("dir_pre_dgrant", s_grant, 2'b10);
    simple(1, 0, 0, 0);
    simple(1, 0, 0, 0);
    chk("dir_pre_igrant", s_grant, 2'b01);
    simple(0, 0, 0, 1);

    // Simultaneous requests out of reset: fetch, data, fetch.
    do_reset();
    simple(1, 1, 0, 0);
    simple(1, 1, 0, 1);
    chk("dir_sim_1", s_grant, 2'b01);
    simple(1, 1, 0, 0);
    simple(1, 1, 0, 1);
    chk("dir_sim_2", s_grant, 2'b10);
    simple(1, 1, 0, 0);
    simple(1, 1, 0, 0);
    chk("dir_sim_3", s_grant, 2'b01);

    // Flush coincident with a memory ack.
    simple(1, 0, 1, 1);
    chk("dir_flush_ack", s_i_ack, 0);
    simple(0, 0, 0, 1);
    chk("dir_flush_idle", s_grant, 2'b00);
    simple(0, 0, 0, 1);

    // Randomized traffic.
    ri = 0; rd = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 2) ri = ~ri;
      if ($urandom_range(0, 9) < 3) rd = ~rd;
      step(ri, rd, 1'($urandom), $urandom_range(0, 99) < 4, 1'($urandom),
           $urandom_range(0, 4) == 0, $urandom, $urandom, $urandom, $urandom);
    end

    // Reset in the middle of a fetch grant.
    simple(1, 0, 0, 0);
    simple(1, 0, 0, 0);
    if (owner != 1) simple(1, 0, 0, 0);
    a_i_m_ack = 1'b1; a_i_syn = 1'b1;
    a_rst = 1'b1;
    #1;
    chk("midrst_grant", a_o_grant, 0);
    chk("midrst_m_syn", a_o_m_syn, 0);
    chk("midrst_i_ack", a_o_i_ack, 0);
    chk("midrst_d_ack", a_o_d_ack, 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the instruction fetch stage and the load/store stage.
- Both requesters use the codebase's syn/ack/last handshake.
- Fetch may stream multi-beat bursts; data accesses are single-beat.
- Sits between the core pipeline and the memory model/bus. It decides grant, muxes request fields, routes responses and forces burst termination when the data stage is waiting.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data/instruction width.
- MAX_BURST, 8, maximum instruction beats per grant (≥1).
- TIMEOUT, 64, cycles allowed without ack (used only with the optional feature).

Ports:
- a_clk  in  1  clock.
- a_rst  in  1  asynchronous reset, active-high.
- a_i_flush  in  1  pipeline flush; aborts an instruction grant.
- a_i_syn  in  1  fetch request.
- a_i_addr  in  AWIDTH  fetch address (next beat).
- a_o_i_ack  out  1  fetch beat valid.
- a_o_i_last  out  1  final fetch beat of this grant.
- a_o_i_instr  out  DWIDTH  fetched instruction.
- a_d_syn  in  1  data request.
- a_d_we  in  1  1 = store.
- a_d_addr  in  AWIDTH  data address.
- a_d_wdata  in  DWIDTH  store data.
- a_o_d_ack  out  1  data access complete.
- a_o_d_rdata  out  DWIDTH  load data.
- a_o_m_syn  out  1  memory request.
- a_o_m_we  out  1  memory write enable.
- a_o_m_addr  out  AWIDTH  memory address.
- a_o_m_wdata  out  DWIDTH  memory write data.
- a_i_m_ack  in  1  memory beat ack.
- a_i_m_rdata  in  DWIDTH  memory read data.
- a_i_m_last  in  1  memory signals end of stream.
- a_o_grant  out  2  01 = instruction, 10 = data, 00 = none.
- a_o_err  out  1  one-cycle timeout pulse.

Behaviour:
- Reset is asynchronous and active-high; one clock, a_clk.
- On reset: FSM = IDLE; all outputs 0; beat counter 0; last_winner = DATA.
- FSM states: IDLE, INSTR, DATA.
- IDLE:
  - Only a_d_syn → DATA.
  - Only a_i_syn → INSTR.
  - Both → the opposite of last_winner (alternation prevents starvation).
  - On entry to a state, latch addr/we/wdata of the winner. a_o_m_syn rises the cycle after the request is sampled (1-cycle grant latency). a_o_grant is registered and matches the state.
- Response routing is combinational. Memory ack/rdata go to the granted requester in the same cycle. The non-granted ack stays 0.
- DATA:
  - Single beat; a_o_m_we = latched a_d_we.
  - On a_i_m_ack: a_o_d_ack = 1 and a_o_d_rdata = a_i_m_rdata.
  - Next cycle: a_o_m_syn = 0, state → IDLE, last_winner = DATA.
  - a_i_m_last is ignored in DATA.
- INSTR:
  - a_o_m_we = 0; beat counter increments on each a_i_m_ack.
  - On ack, a_o_i_last = 1 if any holds:
    - a_i_m_last;
    - counter == MAX_BURST-1;
    - a_d_syn high;
    - a_i_syn low.
  - If a_o_i_last = 1: next cycle a_o_m_syn = 0, state → IDLE, counter cleared, last_winner = INSTR.
  - Otherwise the burst continues: a_o_m_addr reloads from a_i_addr on the ack edge and a_o_m_syn stays high.
- Flush in INSTR:
  - a_i_flush gates a_o_i_ack to 0 in the same cycle, even if a_i_m_ack = 1.
  - Next cycle a_o_m_syn = 0 and state → IDLE.
  - Flush is ignored in DATA and IDLE.
- A requester dropping syn mid-grant does not abort an outstanding beat. The grant ends on the next ack.
- Back-to-back grants: IDLE always lasts at least one cycle between grants.
- Reset mid-transfer: outputs clear immediately; no ack is delivered.

Optional Feature:
- Macro MEM_PORT_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs while a_o_m_syn = 1 and a_i_m_ack = 0; it clears on ack.
  - On reaching TIMEOUT: a_o_err pulses 1 for one cycle, a_o_m_syn drops, state → IDLE, and the requester gets no ack.
- Undefined: no counter; a_o_err is tied 0. The port exists in both builds.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding: IDLE = 2'd0, INSTR = 2'd1, DATA = 2'd2;
  - grant codes: GNT_NONE, GNT_I, GNT_D.
- One sub-module is natural: mem_arb_watchdog, the TIMEOUT counter. It is instantiated only under MEM_PORT_ARB_TIMEOUT_EN.

Test Plan:
- Data only: a_d_syn = 1, we = 0, addr = 0x40; memory acks 2 cycles after syn with rdata 0xDEADBEEF.
  - Expect a_o_d_ack = 1 with rdata 0xDEADBEEF, a_o_grant = 10, then IDLE.
- Fetch burst: a_i_syn held, memory never asserts last, MAX_BURST = 4.
  - Expect exactly 4 a_o_i_ack pulses, the 4th with a_o_i_last = 1, then grant 00 for ≥1 cycle.
- Preemption: a_d_syn rises during beat 2 of a fetch burst.
  - Expect beat 2 ack carries a_o_i_last = 1, next grant = 10, and the following fetch grant = 01 (alternation).
- Simultaneous requests from reset: both syn = 1.
  - Expect INSTR first (last_winner = DATA), then DATA, then INSTR.
- Flush coincident with a_i_m_ack in INSTR.
  - Expect a_o_i_ack = 0 that cycle, a_o_m_syn = 0 next cycle, no further instruction acks.
- MEM_PORT_ARB_TIMEOUT_EN defined, TIMEOUT = 8, memory never acks.
  - Expect a_o_err pulse 8 cycles after a_o_m_syn rises, then IDLE; in the undefined build, a_o_err stays 0 and the FSM remains in the granted state.
